// File: rtl/fifo_tx_pkg.sv
// Shared definitions for the FIFO-draining serial transmitter:
// FSM state encodings, the state enum and the counter width helper.
package fifo_tx_pkg;

  // Legacy-compatible state encodings; the enum below is built from them.
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_LOAD   = 3'd2;
  localparam logic [2:0] ST_START  = 3'd3;
  localparam logic [2:0] ST_DATA   = 3'd4;
  localparam logic [2:0] ST_PARITY = 3'd5;
  localparam logic [2:0] ST_STOP   = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_FETCH  = ST_FETCH,
    S_LOAD   = ST_LOAD,
    S_START  = ST_START,
    S_DATA   = ST_DATA,
    S_PARITY = ST_PARITY,
    S_STOP   = ST_STOP
  } state_e;

  // Bits needed to hold 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_tx_bit_timer.sv
// Bit-period timer: free-running 0..CLKS_PER_BIT-1 counter with a
// synchronous clear; tick marks the last cycle of each bit period.
module fifo_tx_bit_timer #(
  parameter int CLKS_PER_BIT = 16,
  parameter int TMR_W        = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam logic [TMR_W-1:0] LAST = TMR_W'(CLKS_PER_BIT - 1);

  logic [TMR_W-1:0] cnt_reg;

  assign tick = (cnt_reg == LAST);

  // Count bit-period cycles, wrapping at the tick; clear restarts a period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (clr || tick) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_tx_drain.sv
// FIFO consumer that pops one word at a time and serialises it as an
// asynchronous frame: start, data LSB first, optional even parity, stop.
// Optional feature: define FIFO_TX_PARITY_EN to add the parity bit.
module fifo_tx_drain
  import fifo_tx_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic             i_clk,
  input  logic             i_rest,
  input  logic             i_en,
  input  logic             i_empty,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_ren,
  output logic             o_tx,
  output logic             o_busy,
  output logic             o_done
);

  localparam int TMR_W = cnt_width(CLKS_PER_BIT);
  localparam int IDX_W = cnt_width(WIDTH + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  state_e           state_reg, state_next;
  logic [WIDTH-1:0] shift_reg, shift_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic             tx_reg, tx_next;
  logic             ren_reg;
  logic             busy_reg;
  logic             tmr_clr;
  logic             tick;
`ifdef FIFO_TX_PARITY_EN
  logic             par_reg, par_next;
`endif

  fifo_tx_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .TMR_W        (TMR_W)
  ) u_bit_timer (
    .clk   (i_clk),
    .rst_n (i_rest),
    .clr   (tmr_clr),
    .tick  (tick)
  );

  assign o_tx   = tx_reg;
  assign o_ren  = ren_reg;
  assign o_busy = busy_reg;
  assign o_done = (state_reg == S_STOP) && tick;

  // Next-state, datapath and next line value; the line value is derived
  // from the state being entered so o_tx can be registered.
  always_comb begin
    state_next = state_reg;
    shift_next = shift_reg;
    idx_next   = idx_reg;
    tmr_clr    = 1'b0;
    tx_next    = 1'b1;
`ifdef FIFO_TX_PARITY_EN
    par_next   = par_reg;
`endif
    case (state_reg)
      S_IDLE: begin
        tmr_clr = 1'b1;
        if (i_en && !i_empty) begin
          state_next = S_FETCH;
        end
      end
      S_FETCH: begin
        tmr_clr    = 1'b1;
        state_next = S_LOAD;
      end
      S_LOAD: begin
        tmr_clr    = 1'b1;
        shift_next = i_data;
        idx_next   = '0;
`ifdef FIFO_TX_PARITY_EN
        par_next   = ^i_data;
`endif
        state_next = S_START;
      end
      S_START: begin
        if (tick) begin
          state_next = S_DATA;
        end
      end
      S_DATA: begin
        if (tick) begin
          shift_next = shift_reg >> 1;
          if (idx_reg == LAST_IDX) begin
            idx_next = '0;
`ifdef FIFO_TX_PARITY_EN
            state_next = S_PARITY;
`else
            state_next = S_STOP;
`endif
          end else begin
            idx_next = idx_reg + 1'b1;
          end
        end
      end
`ifdef FIFO_TX_PARITY_EN
      S_PARITY: begin
        if (tick) begin
          state_next = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (tick) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    case (state_next)
      S_START:  tx_next = 1'b0;
      S_DATA:   tx_next = shift_next[0];
`ifdef FIFO_TX_PARITY_EN
      S_PARITY: tx_next = par_next;
`endif
      default:  tx_next = 1'b1;
    endcase
  end

  // State and registered outputs; reset abandons any frame in flight.
  always_ff @(posedge i_clk or negedge i_rest) begin
    if (!i_rest) begin
      state_reg <= S_IDLE;
      shift_reg <= '0;
      idx_reg   <= '0;
      tx_reg    <= 1'b1;
      ren_reg   <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      shift_reg <= shift_next;
      idx_reg   <= idx_next;
      tx_reg    <= tx_next;
      ren_reg   <= (state_next == S_FETCH);
      busy_reg  <= (state_next != S_IDLE);
    end
  end

`ifdef FIFO_TX_PARITY_EN
  // Parity of the captured word, held for the parity bit.
  always_ff @(posedge i_clk or negedge i_rest) begin
    if (!i_rest) begin
      par_reg <= 1'b0;
    end else begin
      par_reg <= par_next;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_tx_drain.sv
// Self-checking bench for fifo_tx_drain (WIDTH=8, CLKS_PER_BIT=4).
// A FIFO model feeds the DUT; expected words go to a scoreboard queue
// when pushed and are compared against the decoded line cycle by cycle.
module tb_fifo_tx_drain;

  localparam int W   = 8;
  localparam int CPB = 4;
`ifdef FIFO_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int NBITS     = W + 2 + P;
  localparam int FRAME_CYC = NBITS * CPB;

  logic         i_clk;
  logic         i_rest;
  logic         i_en;
  logic         i_empty;
  logic [W-1:0] i_data;
  logic         o_ren;
  logic         o_tx;
  logic         o_busy;
  logic         o_done;

  int n_cmp = 0;
  int n_err = 0;
  int ren_cnt = 0;

  logic [W-1:0] fifo_q[$];
  logic [W-1:0] exp_q[$];

  fifo_tx_drain #(
    .WIDTH        (W),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .i_clk   (i_clk),
    .i_rest  (i_rest),
    .i_en    (i_en),
    .i_empty (i_empty),
    .i_data  (i_data),
    .o_ren   (o_ren),
    .o_tx    (o_tx),
    .o_busy  (o_busy),
    .o_done  (o_done)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // FIFO model: a read enable seen high presents the next word on i_data,
  // where it stays valid through the following (capture) cycle.
  always @(negedge i_clk) begin
    if (o_ren === 1'b1) begin
      ren_cnt = ren_cnt + 1;
      if (fifo_q.size() > 0) i_data = fifo_q.pop_front();
    end
    i_empty = (fifo_q.size() == 0);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_word(input logic [W-1:0] d);
    fifo_q.push_back(d);
    exp_q.push_back(d);
    i_empty = 1'b0;
  endtask

  // Expected line value for every cycle of a frame, index 0 = first start cycle.
  function automatic logic [FRAME_CYC-1:0] exp_frame(input logic [W-1:0] d);
    logic [NBITS-1:0]     b;
    logic [FRAME_CYC-1:0] r;
    b = '0;
    for (int i = 0; i < W; i++) b[i+1] = d[i];
`ifdef FIFO_TX_PARITY_EN
    b[W+1] = ^d;
`endif
    b[NBITS-1] = 1'b1;
    for (int c = 0; c < FRAME_CYC; c++) r[c] = b[c / CPB];
    return r;
  endfunction

  // Wait (bounded) for a start bit, then sample o_tx / o_done for one frame.
  // gap counts the high cycles seen before the start bit.
  task automatic rx_frame(input int drop_at, output logic [FRAME_CYC-1:0] smp,
                          output int gap, output int done_at, output int done_cnt,
                          output bit found);
    gap = 0; found = 1'b0; smp = '0; done_at = -1; done_cnt = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge i_clk);
      if (o_tx === 1'b0) begin
        found = 1'b1;
        break;
      end
      gap++;
    end
    if (!found) return;
    for (int c = 0; c < FRAME_CYC; c++) begin
      if (c > 0) @(negedge i_clk);
      smp[c] = o_tx;
      if (o_done === 1'b1) begin
        done_cnt++;
        done_at = c + 1;
      end
      if (c == drop_at) i_en = 1'b0;
    end
  endtask

  task automatic test_reset;
    i_rest = 1'b1; i_en = 1'b0; i_empty = 1'b1; i_data = '0;
    #2 i_rest = 1'b0;
    #3;
    n_cmp++; if (o_tx !== 1'b1)   begin n_err++; $display("FAIL reset_tx got=%b want=1", o_tx); end
    n_cmp++; if (o_ren !== 1'b0)  begin n_err++; $display("FAIL reset_ren got=%b want=0", o_ren); end
    n_cmp++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b want=0", o_busy); end
    n_cmp++; if (o_done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b want=0", o_done); end
    repeat (2) @(negedge i_clk);
    i_rest = 1'b1;
    @(negedge i_clk);
    $display("reset: tx=%b ren=%b busy=%b done=%b", o_tx, o_ren, o_busy, o_done);
  endtask

  task automatic test_single(input logic [W-1:0] d, input string tag);
    logic [FRAME_CYC-1:0] smp;
    logic [W-1:0] e;
    int gap, done_at, done_cnt, ren0;
    bit found;
    ren0 = ren_cnt;
    push_word(d);
    i_en = 1'b1;
    rx_frame(-1, smp, gap, done_at, done_cnt, found);
    e = exp_q.pop_front();
    $display("%s: word=%02h found=%0d done_at=%0d done_cnt=%0d line=%b", tag, e, found, done_at, done_cnt, smp);
    n_cmp++; if (smp !== exp_frame(e)) begin n_err++; $display("FAIL %s_frame got=%b want=%b", tag, smp, exp_frame(e)); end
    n_cmp++; if (done_at !== FRAME_CYC) begin n_err++; $display("FAIL %s_done_at got=%0d want=%0d", tag, done_at, FRAME_CYC); end
    n_cmp++; if (done_cnt !== 1) begin n_err++; $display("FAIL %s_done_cnt got=%0d want=1", tag, done_cnt); end
    @(negedge i_clk);
    n_cmp++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL %s_busy_after got=%b want=0", tag, o_busy); end
    repeat (5) @(negedge i_clk);
    n_cmp++; if (ren_cnt - ren0 !== 1) begin n_err++; $display("FAIL %s_ren_count got=%0d want=1", tag, ren_cnt - ren0); end
  endtask

  task automatic test_empty_hold;
    logic [FRAME_CYC-1:0] smp;
    logic [W-1:0] e;
    int gap, done_at, done_cnt;
    bit found, saw_ren, saw_low;
    saw_ren = 1'b0; saw_low = 1'b0;
    i_en = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge i_clk);
      if (o_ren !== 1'b0) saw_ren = 1'b1;
      if (o_tx !== 1'b1) saw_low = 1'b1;
    end
    $display("empty_hold: saw_ren=%0d saw_low=%0d", saw_ren, saw_low);
    n_cmp++; if (saw_ren !== 1'b0) begin n_err++; $display("FAIL empty_ren got=%b want=0", saw_ren); end
    n_cmp++; if (saw_low !== 1'b0) begin n_err++; $display("FAIL empty_tx_low got=%b want=0", saw_low); end
    push_word(8'h5A);
    @(negedge i_clk);
    n_cmp++; if (o_ren !== 1'b1) begin n_err++; $display("FAIL empty_ren_latency got=%b want=1", o_ren); end
    rx_frame(-1, smp, gap, done_at, done_cnt, found);
    e = exp_q.pop_front();
    $display("empty_hold frame: word=%02h found=%0d line=%b", e, found, smp);
    n_cmp++; if (smp !== exp_frame(e)) begin n_err++; $display("FAIL empty_frame got=%b want=%b", smp, exp_frame(e)); end
    repeat (3) @(negedge i_clk);
  endtask

  task automatic test_back_to_back;
    logic [FRAME_CYC-1:0] smp;
    logic [W-1:0] e;
    logic [W-1:0] words [3];
    int gap, done_at, done_cnt, ren0;
    bit found;
    words[0] = 8'h3C; words[1] = 8'h81; words[2] = 8'h00;
    ren0 = ren_cnt;
    for (int i = 0; i < 3; i++) push_word(words[i]);
    i_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rx_frame(-1, smp, gap, done_at, done_cnt, found);
      e = exp_q.pop_front();
      $display("b2b frame %0d: word=%02h gap=%0d done_at=%0d line=%b", i, e, gap, done_at, smp);
      n_cmp++; if (smp !== exp_frame(e)) begin n_err++; $display("FAIL b2b_frame%0d got=%b want=%b", i, smp, exp_frame(e)); end
      if (i > 0) begin
        n_cmp++; if (gap !== 3) begin n_err++; $display("FAIL b2b_gap%0d got=%0d want=3", i, gap); end
      end
    end
    repeat (10) @(negedge i_clk);
    n_cmp++; if (ren_cnt - ren0 !== 3) begin n_err++; $display("FAIL b2b_ren_count got=%0d want=3", ren_cnt - ren0); end
    n_cmp++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL b2b_idle_busy got=%b want=0", o_busy); end
  endtask

  task automatic test_en_drop;
    logic [FRAME_CYC-1:0] smp;
    logic [W-1:0] e;
    int gap, done_at, done_cnt, ren0;
    bit found, saw_low;
    ren0 = ren_cnt;
    saw_low = 1'b0;
    push_word(8'h96);
    push_word(8'h35);
    i_en = 1'b1;
    rx_frame(12, smp, gap, done_at, done_cnt, found);
    e = exp_q.pop_front();
    $display("en_drop frame: word=%02h done_at=%0d line=%b", e, done_at, smp);
    n_cmp++; if (smp !== exp_frame(e)) begin n_err++; $display("FAIL en_drop_frame got=%b want=%b", smp, exp_frame(e)); end
    n_cmp++; if (done_at !== FRAME_CYC) begin n_err++; $display("FAIL en_drop_done_at got=%0d want=%0d", done_at, FRAME_CYC); end
    for (int k = 0; k < 60; k++) begin
      @(negedge i_clk);
      if (o_tx !== 1'b1) saw_low = 1'b1;
    end
    n_cmp++; if (ren_cnt - ren0 !== 1) begin n_err++; $display("FAIL en_drop_ren_count got=%0d want=1", ren_cnt - ren0); end
    n_cmp++; if (saw_low !== 1'b0) begin n_err++; $display("FAIL en_drop_extra_frame got=%b want=0", saw_low); end
    n_cmp++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL en_drop_busy got=%b want=0", o_busy); end
  endtask

  task automatic test_reset_midframe;
    logic [FRAME_CYC-1:0] smp;
    logic [W-1:0] lost, e;
    int gap, done_at, done_cnt;
    bit found;
    // 0x35 is still queued from the enable-drop scenario; its bit 3 is 0.
    push_word(8'hC3);
    i_en = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge i_clk);
      if (o_tx === 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    n_cmp++; if (found !== 1'b1) begin n_err++; $display("FAIL midrst_start got=%b want=1", found); end
    repeat (17) @(negedge i_clk);
    lost = exp_q.pop_front();
    n_cmp++; if (o_tx !== lost[3]) begin n_err++; $display("FAIL midrst_bit3 got=%b want=%b", o_tx, lost[3]); end
    #2 i_rest = 1'b0;
    #1;
    $display("midrst: lost=%02h tx=%b busy=%b ren=%b", lost, o_tx, o_busy, o_ren);
    n_cmp++; if (o_tx !== 1'b1)   begin n_err++; $display("FAIL midrst_tx got=%b want=1", o_tx); end
    n_cmp++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy got=%b want=0", o_busy); end
    n_cmp++; if (o_ren !== 1'b0)  begin n_err++; $display("FAIL midrst_ren got=%b want=0", o_ren); end
    repeat (2) @(negedge i_clk);
    i_rest = 1'b1;
    rx_frame(-1, smp, gap, done_at, done_cnt, found);
    e = exp_q.pop_front();
    $display("midrst new frame: word=%02h found=%0d line=%b", e, found, smp);
    n_cmp++; if (smp !== exp_frame(e)) begin n_err++; $display("FAIL midrst_frame got=%b want=%b", smp, exp_frame(e)); end
    n_cmp++; if (done_at !== FRAME_CYC) begin n_err++; $display("FAIL midrst_done_at got=%0d want=%0d", done_at, FRAME_CYC); end
    repeat (5) @(negedge i_clk);
  endtask

  initial begin
    test_reset();
    test_single(8'hA5, "single");
    test_single(8'h07, "parity");
    test_empty_hold();
    test_back_to_back();
    test_en_drop();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
